// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART transmitter and receiver
`timescale 1ns/1ps
module uart_transceiver #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID_BIT  = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_e;

  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_active_q, tx_active_d;
  logic          tx_done_q, tx_done_d;

  // Serial line is decoded from state so an async reset forces it high at once.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_byte_d   = tx_byte_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    o_TX_Serial = 1'b1;
    case (tx_state_q)
      S_IDLE: begin
        if (i_TX_DV) begin
          tx_byte_d   = i_TX_Byte;
          tx_active_d = 1'b1;
          tx_cnt_d    = '0;
          tx_idx_d    = '0;
          tx_state_d  = S_START;
        end
      end
      S_START: begin
        o_TX_Serial = 1'b0;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        o_TX_Serial = tx_byte_q[tx_idx_q];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_done_d   = 1'b1;
          tx_active_d = 1'b0;
          tx_state_d  = S_CLEANUP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_byte_q   <= '0;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign o_TX_Active = tx_active_q;
  assign o_TX_Done   = tx_done_q;

  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_dv_q, rx_dv_d;
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;

  // Start is confirmed at mid-bit; every later sample lands mid-bit too.
  always_comb begin
    rx_meta_d  = i_RX_Serial;
    rx_sync_d  = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == MID_BIT) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_sync_q;
          rx_idx_d             = rx_idx_q + 1'b1;
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_CLEANUP;
          if (rx_sync_q) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  assign o_RX_DV   = rx_dv_q;
  assign o_RX_Byte = rx_byte_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed and randomized bench for uart_transceiver
`timescale 1ns/1ps
module tb_uart_transceiver;
  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active, tx_serial, tx_done;
  logic       rx_serial, rx_dv;
  logic [7:0] rx_byte;
  logic       loopback, rx_drv;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rx_got[$];
  logic [7:0] exp_q[$];

  always #20 clk = ~clk;

  assign rx_serial = loopback ? (tx_active ? tx_serial : 1'b1) : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Rst_L    (rst_n),
    .i_TX_DV    (tx_dv),
    .i_TX_Byte  (tx_byte),
    .o_TX_Active(tx_active),
    .o_TX_Serial(tx_serial),
    .o_TX_Done  (tx_done),
    .i_RX_Serial(rx_serial),
    .o_RX_DV    (rx_dv),
    .o_RX_Byte  (rx_byte)
  );

  always @(negedge clk) if (rst_n && rx_dv) rx_got.push_back(rx_byte);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tx(input logic [7:0] b);
    tx_byte = b;
    tx_dv   = 1'b1;
    @(negedge clk);
    tx_dv   = 1'b0;
    tx_byte = 8'($urandom);
  endtask

  task automatic wait_tx_done(input string tag);
    int n;
    n = 0;
    while (tx_done !== 1'b1 && n < 12 * CPB) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx_done), 32'd1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int k;
    k = 0;
    while (rx_got.size() < n && k < 3 * CPB) begin
      @(negedge clk);
      k++;
    end
    check(tag, rx_got.size(), n);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, rx_got.size(), exp_q.size());
    foreach (exp_q[i]) if (i < rx_got.size()) check(tag, 32'(rx_got[i]), 32'(exp_q[i]));
    rx_got.delete();
    exp_q.delete();
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      tick(CPB);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [9:0] frame;
    int bad_ser, act_cycles, done_in_frame;

    rst_n = 1'b0; tx_dv = 1'b0; tx_byte = 8'h00; loopback = 1'b1; rx_drv = 1'b1;
    tick(3);
    check("rst_tx_serial", 32'(tx_serial), 32'd1);
    check("rst_tx_active", 32'(tx_active), 32'd0);
    check("rst_tx_done",   32'(tx_done),   32'd0);
    check("rst_rx_dv",     32'(rx_dv),     32'd0);
    check("rst_rx_byte",   32'(rx_byte),   32'h00);
    rst_n = 1'b1;
    tick(5);

    // TX waveform of 0x3F with an ignored mid-frame request
    frame = {1'b1, 8'h3F, 1'b0};
    bad_ser = 0; act_cycles = 0; done_in_frame = 0;
    pulse_tx(8'h3F);
    for (int c = 0; c < 10 * CPB; c++) begin
      if (tx_serial !== frame[c / CPB]) bad_ser++;
      if (tx_active === 1'b1) act_cycles++;
      if (tx_done === 1'b1) done_in_frame++;
      tx_dv = (c == 5 * CPB + 7);
      if (c == 5 * CPB + 7) tx_byte = 8'h00;
      @(negedge clk);
    end
    tx_dv = 1'b0;
    check("wave_bad_serial_cycles", bad_ser, 0);
    check("wave_active_cycles", act_cycles, 10 * CPB);
    check("wave_done_in_frame", done_in_frame, 0);
    check("wave_done_at_end", 32'(tx_done), 32'd1);
    check("wave_active_fall", 32'(tx_active), 32'd0);
    tick(1);
    check("wave_done_one_cycle", 32'(tx_done), 32'd0);
    wait_rx(1, "loop_rx_count");
    tick(2 * CPB);
    exp_q.push_back(8'h3F);
    compare_rx("loop_3f");
    check("ignored_dv_no_frame", 32'(tx_active), 32'd0);

    // Back-to-back loopback, directed then random bytes
    exp_q = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
    repeat (4) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) begin
      pulse_tx(exp_q[i]);
      wait_tx_done("b2b_done");
      tick(1);
    end
    wait_rx(exp_q.size(), "b2b_rx_wait");
    compare_rx("b2b_byte");

    // Short low glitch on RX must not start a frame
    loopback = 1'b0; rx_drv = 1'b1;
    tick(5);
    rx_drv = 1'b0;
    tick(50);
    rx_drv = 1'b1;
    tick(3 * CPB);
    check("glitch_no_dv", rx_got.size(), 0);
    send_rx_frame(8'hC3, 1'b1);
    wait_rx(1, "after_glitch_wait");
    exp_q.push_back(8'hC3);
    compare_rx("after_glitch");

    // Framing error keeps the previous byte
    send_rx_frame(8'h81, 1'b0);
    tick(3 * CPB);
    check("frame_err_no_dv", rx_got.size(), 0);
    check("frame_err_hold", 32'(rx_byte), 32'hC3);
    send_rx_frame(8'h42, 1'b1);
    wait_rx(1, "after_frame_err_wait");
    exp_q.push_back(8'h42);
    compare_rx("after_frame_err");

    // Random directly-driven frames with random idle gaps
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'($urandom));
      send_rx_frame(exp_q[i], 1'b1);
      tick($urandom_range(0, 20));
    end
    wait_rx(4, "rand_rx_wait");
    compare_rx("rand_rx");

    // Reset during TX data bit 3
    loopback = 1'b1;
    tick(5);
    pulse_tx(8'h3F);
    tick(4 * CPB + CPB / 2);
    #5 rst_n = 1'b0;
    #1;
    check("midrst_tx_serial", 32'(tx_serial), 32'd1);
    check("midrst_tx_active", 32'(tx_active), 32'd0);
    check("midrst_tx_done",   32'(tx_done),   32'd0);
    check("midrst_rx_dv",     32'(rx_dv),     32'd0);
    check("midrst_rx_byte",   32'(rx_byte),   32'h00);
    @(negedge clk);
    tick(2);
    rst_n = 1'b1;
    rx_got.delete();
    tick(5);
    pulse_tx(8'h3F);
    wait_tx_done("post_rst_done");
    wait_rx(1, "post_rst_rx_wait");
    exp_q.push_back(8'h3F);
    compare_rx("post_rst_3f");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
